mem_port_arbiter: RTL

Sequential two-master arbiter that shares the single unified memory port of the multi-cycle MIPS32 core between master 0 (the core's fetch/load/store path) and master 1 (a loader/DMA or debug port). It latches one request at a time, drives the memory strobes for a fixed number of wait cycles, captures read data and returns a one-cycle acknowledge to the owning master. Sits between the core's `address`/`data_out`/`MemRead`/`MemWrite` signals and the memory model.

---
 rtl/mem_port_arbiter.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// -----------------------------------------------------------------------------
// mem_port_arbiter
//
// Shares one unified memory port between two masters. Master 0 is the core's
// fetch/load/store path and master 1 is a loader/DMA or debug port. One request
// is latched at a time. The memory strobe is held for MEM_LAT cycles, read data
// is captured at the end of the access, and a one-cycle acknowledge goes back to
// the master that owns the transaction.
//
// Parameters
//   MEM_LAT    cycles the strobe is held before mem_rdata is valid (1..15)
//
// Ports
//   clk        clock; all state changes on the rising edge
//   nrst       asynchronous reset, active-high (asserted = 1)
//   mN_req     master N request level, held until mN_ack
//   mN_we      master N write (1) / read (0)
//   mN_addr    master N byte address
//   mN_wdata   master N write data
//   mN_rdata   master N read data (registered, held until its next read)
//   mN_ack     master N one-cycle completion pulse
//   mem_addr   registered memory address
//   mem_wdata  registered memory write data
//   mem_re     memory read strobe
//   mem_we     memory write strobe
//   mem_rdata  memory read data
//   owner      index of the current or last granted master
//   busy       high whenever the FSM is not in IDLE
//
// Build option
//   ARB_ROUND_ROBIN_EN  when defined, simultaneous requests alternate. The
//                       grant goes to the master that is not the current
//                       owner. When undefined, master 0 has fixed priority.
// -----------------------------------------------------------------------------
module mem_port_arbiter #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk,
    input  logic        nrst,
    input  logic        m0_req,
    input  logic        m0_we,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    output logic [31:0] m0_rdata,
    output logic        m0_ack,
    input  logic        m1_req,
    input  logic        m1_we,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    output logic [31:0] m1_rdata,
    output logic        m1_ack,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic        mem_re,
    output logic        mem_we,
    input  logic [31:0] mem_rdata,
    output logic        owner,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t      state_q;
    logic [3:0]  cnt_q;
    logic        owner_q;
    logic        mem_re_q;
    logic        mem_we_q;
    logic [31:0] mem_addr_q;
    logic [31:0] mem_wdata_q;
    logic [31:0] m0_rdata_q;
    logic [31:0] m1_rdata_q;
    logic        m0_ack_q;
    logic        m1_ack_q;

    // Grant decision and the winner's request fields, used only in IDLE.
    logic        any_req;
    logic        grant_d;
    logic        sel_we_d;
    logic [31:0] sel_addr_d;
    logic [31:0] sel_wdata_d;

    assign any_req = m0_req | m1_req;

    always_comb begin
        grant_d = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        // On a conflict, grant the master that did not own the last
        // transaction. owner resets to 1, so master 0 wins the first conflict.
        if (m0_req && m1_req) begin
            grant_d = ~owner_q;
        end else begin
            grant_d = ~m0_req;
        end
`else
        grant_d = ~m0_req;
`endif
        sel_we_d    = grant_d ? m1_we    : m0_we;
        sel_addr_d  = grant_d ? m1_addr  : m0_addr;
        sel_wdata_d = grant_d ? m1_wdata : m0_wdata;
    end

    always_ff @(posedge clk or posedge nrst) begin
        if (nrst) begin
            state_q     <= IDLE;
            cnt_q       <= 4'd0;
            owner_q     <= 1'b1;
            mem_re_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wdata_q <= 32'd0;
            m0_rdata_q  <= 32'd0;
            m1_rdata_q  <= 32'd0;
            m0_ack_q    <= 1'b0;
            m1_ack_q    <= 1'b0;
        end else begin
            case (state_q)
                // Arbitrate and latch the winning request.
                IDLE: begin
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                    if (any_req) begin
                        state_q     <= ACCESS;
                        owner_q     <= grant_d;
                        mem_addr_q  <= sel_addr_d;
                        mem_wdata_q <= sel_wdata_d;
                        mem_re_q    <= ~sel_we_d;
                        mem_we_q    <= sel_we_d;
                        cnt_q       <= 4'(MEM_LAT - 1);
                    end
                end

                // Hold the strobes for MEM_LAT cycles. The transaction completes
                // even if the requester drops req here.
                ACCESS: begin
                    if (cnt_q == 4'd0) begin
                        state_q  <= DONE;
                        mem_re_q <= 1'b0;
                        mem_we_q <= 1'b0;
                        // mem_we_q still reflects the latched direction here.
                        if (!mem_we_q) begin
                            if (owner_q) begin
                                m1_rdata_q <= mem_rdata;
                            end else begin
                                m0_rdata_q <= mem_rdata;
                            end
                        end
                        m0_ack_q <= ~owner_q;
                        m1_ack_q <= owner_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end

                // The ack is visible in this cycle. Return to IDLE unconditionally.
                DONE: begin
                    state_q  <= IDLE;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                end

                default: begin
                    state_q  <= IDLE;
                    mem_re_q <= 1'b0;
                    mem_we_q <= 1'b0;
                    m0_ack_q <= 1'b0;
                    m1_ack_q <= 1'b0;
                end
            endcase
        end
    end

    assign m0_rdata  = m0_rdata_q;
    assign m1_rdata  = m1_rdata_q;
    assign m0_ack    = m0_ack_q;
    assign m1_ack    = m1_ack_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign mem_re    = mem_re_q;
    assign mem_we    = mem_we_q;
    assign owner     = owner_q;
    assign busy      = (state_q != IDLE);

endmodule
